// File: rtl/uart_rx_seq_trig.sv
// rtl/uart_rx_seq_trig.sv - UART receiver that pulses a trigger on a masked multi-frame match
module uart_rx_seq_trig #(
  parameter int DATA_W    = 8,
  parameter int SEQ_LEN   = 1,
  parameter int PARITY_EN = 0,
  parameter int BAUD_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX,
  input  logic [BAUD_W-1:0]         baud_cnt,
  input  logic [SEQ_LEN*DATA_W-1:0] match,
  input  logic [SEQ_LEN*DATA_W-1:0] mask,
  input  logic                      parity_odd,
  output logic                      UARTtrig,
  output logic                      frame_err
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int SEQ_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rx_sync;
  logic                rxs;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BAUD_W-1:0]   limit;
  logic [BAUD_W:0]     baud_nxt;
  logic                tick;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_err_q, par_err_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                trig_d, ferr_d;
  logic [DATA_W-1:0]   cur_match, cur_mask;
  logic                hit_cur, hit_0, seq_last;

  assign rxs = rx_sync[1];

  // Start bit is checked at its midpoint; every later bit one full period after the previous sample.
  // The >= compare keeps the counter from running away if baud_cnt shrinks mid-frame.
  assign limit    = (state_q == S_START) ? (baud_cnt >> 1) : baud_cnt;
  assign baud_nxt = {1'b0, baud_q} + {{BAUD_W{1'b0}}, 1'b1};
  assign tick     = baud_nxt >= {1'b0, limit};

  // Pick the pattern slot the sequencer is currently waiting on.
  always_comb begin
    cur_match = '0;
    cur_mask  = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (seq_q == SEQ_W'(k)) begin
        cur_match = match[k*DATA_W +: DATA_W];
        cur_mask  = mask[k*DATA_W +: DATA_W];
      end
    end
  end

  assign hit_cur  = ((shreg_q ^ cur_match) & ~cur_mask) == '0;
  assign hit_0    = ((shreg_q ^ match[DATA_W-1:0]) & ~mask[DATA_W-1:0]) == '0;
  assign seq_last = seq_q == SEQ_W'(SEQ_LEN - 1);

  // Next-state, datapath updates and output pulses for the receive FSM and sequencer.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    seq_d     = seq_q;
    trig_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d   = S_START;
          baud_d    = '0;
          bit_d     = '0;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          baud_d  = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_nxt[BAUD_W-1:0];
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_d  = '0;
          shreg_d = {rxs, shreg_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
          end
        end else begin
          baud_d = baud_nxt[BAUD_W-1:0];
        end
      end
      S_PAR: begin
        if (tick) begin
          baud_d    = '0;
          par_err_d = ((^shreg_q) ^ rxs) != parity_odd;
          state_d   = S_STOP;
        end else begin
          baud_d = baud_nxt[BAUD_W-1:0];
        end
      end
      S_STOP: begin
        if (tick) begin
          baud_d = '0;
          if (rxs && !par_err_q) begin
            state_d = S_IDLE;
            if (hit_cur && seq_last) begin
              trig_d = 1'b1;
              seq_d  = '0;
            end else if (hit_cur) begin
              seq_d = seq_q + SEQ_W'(1);
            end else begin
              seq_d = (SEQ_LEN > 1 && hit_0) ? SEQ_W'(1) : '0;
            end
          end else begin
            ferr_d  = 1'b1;
            seq_d   = '0;
            state_d = S_WAIT_HI;
          end
        end else begin
          baud_d = baud_nxt[BAUD_W-1:0];
        end
      end
      S_WAIT_HI: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, synchroniser and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_sync   <= 2'b11;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      seq_q     <= '0;
      UARTtrig  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_sync   <= {rx_sync[0], RX};
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      seq_q     <= seq_d;
      UARTtrig  <= trig_d;
      frame_err <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_seq_trig.sv
// tb/tb_uart_rx_seq_trig.sv - self-checking bench for uart_rx_seq_trig
module tb_uart_rx_seq_trig;

  localparam int BAUD = 16;
  localparam int LAT8 = 3 + BAUD / 2 + BAUD * 9;
  localparam int LAT9 = 3 + BAUD / 2 + BAUD * 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_a = 1'b1;
  logic        rx_p = 1'b1;
  logic [15:0] baud = 16'(BAUD);
  logic [7:0]  m1 = 8'h00, k1 = 8'h00, m3 = 8'h00, k3 = 8'h00;
  logic [15:0] m2 = 16'h3412, k2 = 16'h0000;
  logic        po = 1'b0;
  logic        t1, e1, t2, e2, t3, e3;

  int cyc = 0;
  int n_trg[3]    = '{0, 0, 0};
  int n_err[3]    = '{0, 0, 0};
  int last_trg[3] = '{0, 0, 0};
  int last_err[3] = '{0, 0, 0};
  int viol = 0;
  logic [2:0] ptrg = 3'b000, perr = 3'b000;
  int tests = 0, fails = 0;
  int idx2 = 0;

  uart_rx_seq_trig #(.DATA_W(8), .SEQ_LEN(1), .PARITY_EN(0), .BAUD_W(16)) u_s1 (
    .clk(clk), .rst(rst), .RX(rx_a), .baud_cnt(baud), .match(m1), .mask(k1),
    .parity_odd(po), .UARTtrig(t1), .frame_err(e1));

  uart_rx_seq_trig #(.DATA_W(8), .SEQ_LEN(2), .PARITY_EN(0), .BAUD_W(16)) u_s2 (
    .clk(clk), .rst(rst), .RX(rx_a), .baud_cnt(baud), .match(m2), .mask(k2),
    .parity_odd(po), .UARTtrig(t2), .frame_err(e2));

  uart_rx_seq_trig #(.DATA_W(8), .SEQ_LEN(1), .PARITY_EN(1), .BAUD_W(16)) u_p (
    .clk(clk), .rst(rst), .RX(rx_p), .baud_cnt(baud), .match(m3), .mask(k3),
    .parity_odd(po), .UARTtrig(t3), .frame_err(e3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters, timestamps and shape monitor (sampled on the falling edge)
  always @(negedge clk) begin
    logic [2:0] tv, ev;
    tv = {t3, t2, t1};
    ev = {e3, e2, e1};
    for (int i = 0; i < 3; i++) begin
      if (tv[i]) begin n_trg[i]++; last_trg[i] = cyc; end
      if (ev[i]) begin n_err[i]++; last_err[i] = cyc; end
      if ((tv[i] && ev[i]) || (tv[i] && ptrg[i]) || (ev[i] && perr[i])) viol++;
    end
    ptrg = tv;
    perr = ev;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit hit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] k);
    return ((d ^ m) & ~k) == 8'h00;
  endfunction

  // two-slot sequence reference: which slot is awaited, advanced per received frame
  task automatic model_s2(input logic [7:0] d, input bit good, output int fire);
    logic [7:0] sm, sk;
    fire = 0;
    if (!good) begin
      idx2 = 0;
      return;
    end
    sm = (idx2 == 0) ? m2[7:0] : m2[15:8];
    sk = (idx2 == 0) ? k2[7:0] : k2[15:8];
    if (hit(d, sm, sk)) begin
      if (idx2 == 1) begin fire = 1; idx2 = 0; end
      else idx2 = 1;
    end else begin
      idx2 = hit(d, m2[7:0], k2[7:0]) ? 1 : 0;
    end
  endtask

  task automatic set_line(input bit on_p, input logic v);
    if (on_p) rx_p = v;
    else rx_a = v;
  endtask

  task automatic drive_frame(input bit on_p, input logic [8:0] bits, input int nbits,
                             input bit stop_v, input int low_hold, output int st);
    @(posedge clk); #1;
    st = cyc;
    set_line(on_p, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      repeat (BAUD) @(posedge clk);
      #1 set_line(on_p, bits[i]);
    end
    repeat (BAUD) @(posedge clk);
    #1 set_line(on_p, stop_v);
    repeat (BAUD) @(posedge clk);
    #1;
    if (!stop_v) begin
      repeat (low_hold) @(posedge clk);
      #1;
    end
    set_line(on_p, 1'b1);
    repeat (6) @(posedge clk);
  endtask

  // frame on the shared non-parity line; an expectation of -1 means "ask the reference"
  task automatic a_frame(input logic [7:0] d, input bit stop_ok, input int x1_in,
                         input int x2_in, input int x_err, input string tag);
    int b_t1, b_t2, b_e1, b_e2, st, m_t2, x1, x2;
    x1 = (x1_in < 0) ? ((stop_ok && hit(d, m1, k1)) ? 1 : 0) : x1_in;
    model_s2(d, stop_ok, m_t2);
    x2 = (x2_in < 0) ? m_t2 : x2_in;
    b_t1 = n_trg[0]; b_t2 = n_trg[1]; b_e1 = n_err[0]; b_e2 = n_err[1];
    drive_frame(1'b0, {1'b0, d}, 8, stop_ok, 40, st);
    chk({tag, " s1 trig"}, n_trg[0] - b_t1, x1);
    chk({tag, " s2 trig"}, n_trg[1] - b_t2, x2);
    chk({tag, " s1 ferr"}, n_err[0] - b_e1, x_err);
    chk({tag, " s2 ferr"}, n_err[1] - b_e2, x_err);
    if (x1 == 1 && n_trg[0] > b_t1) chk({tag, " s1 trig lat"}, last_trg[0] - st, LAT8);
    if (x2 == 1 && n_trg[1] > b_t2) chk({tag, " s2 trig lat"}, last_trg[1] - st, LAT8);
    if (x_err == 1 && n_err[0] > b_e1) chk({tag, " s1 ferr lat"}, last_err[0] - st, LAT8);
  endtask

  task automatic p_frame(input logic [7:0] d, input logic pbit, input int x_t,
                         input int x_e, input string tag);
    int b_t, b_e, st;
    b_t = n_trg[2]; b_e = n_err[2];
    drive_frame(1'b1, {pbit, d}, 9, 1'b1, 0, st);
    chk({tag, " par trig"}, n_trg[2] - b_t, x_t);
    chk({tag, " par ferr"}, n_err[2] - b_e, x_e);
    if (x_t == 1 && n_trg[2] > b_t) chk({tag, " par trig lat"}, last_trg[2] - st, LAT9);
    if (x_e == 1 && n_err[2] > b_e) chk({tag, " par ferr lat"}, last_err[2] - st, LAT9);
  endtask

  typedef struct {
    logic [7:0] m, k, d;
    bit         stop_ok;
    int         exp_t1;
    int         exp_err;
  } a_vec_t;

  typedef struct {
    logic [7:0] d, m, k;
    logic       odd, pbit;
    int         exp_t;
    int         exp_e;
  } p_vec_t;

  initial begin
    a_vec_t av[8];
    p_vec_t pv[6];
    int b[6];
    logic [7:0] d, pbit_r;
    bit good;

    av[0] = '{8'hA5, 8'h00, 8'hA5, 1'b1, 1, 0};
    av[1] = '{8'hA5, 8'h00, 8'hA4, 1'b1, 0, 0};
    av[2] = '{8'hA0, 8'h0F, 8'hAF, 1'b1, 1, 0};
    av[3] = '{8'hA0, 8'h0F, 8'hA3, 1'b1, 1, 0};
    av[4] = '{8'hA0, 8'h0F, 8'hB0, 1'b1, 0, 0};
    av[5] = '{8'h00, 8'hFF, 8'h5A, 1'b1, 1, 0};
    av[6] = '{8'hA5, 8'h00, 8'hA5, 1'b0, 0, 1};
    av[7] = '{8'h81, 8'h00, 8'h81, 1'b1, 1, 0};

    pv[0] = '{8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 1, 0};
    pv[1] = '{8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 0, 1};
    pv[2] = '{8'h03, 8'h03, 8'h00, 1'b1, 1'b1, 1, 0};
    pv[3] = '{8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1, 0};
    pv[4] = '{8'h07, 8'h00, 8'hFF, 1'b1, 1'b1, 0, 1};
    pv[5] = '{8'h5A, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", int'({t1, e1, t2, e2, t3, e3}), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // single-slot match/mask table (second DUT follows the reference)
    for (int i = 0; i < 8; i++) begin
      m1 = av[i].m; k1 = av[i].k;
      a_frame(av[i].d, av[i].stop_ok, av[i].exp_t1, -1, av[i].exp_err, $sformatf("vec%0d", i));
    end

    // two-frame sequences; a bad frame first clears any pending slot
    m2 = 16'h3412; k2 = 16'h0000; m1 = 8'h00; k1 = 8'h00;
    a_frame(8'h00, 1'b0, 0, 0, 1, "seq clr");
    a_frame(8'h12, 1'b1, -1, 0, 0, "seqA 12");
    a_frame(8'h34, 1'b1, -1, 1, 0, "seqA 34");
    a_frame(8'h12, 1'b1, -1, 0, 0, "seqB 12");
    a_frame(8'h12, 1'b1, -1, 0, 0, "seqB 12b");
    a_frame(8'h34, 1'b1, -1, 1, 0, "seqB 34");
    a_frame(8'h12, 1'b1, -1, 0, 0, "seqC 12");
    a_frame(8'h55, 1'b1, -1, 0, 0, "seqC 55");
    a_frame(8'h34, 1'b1, -1, 0, 0, "seqC 34");
    a_frame(8'h12, 1'b1, -1, 0, 0, "seqD 12");
    a_frame(8'h34, 1'b0, 0, 0, 1, "seqD bad");
    a_frame(8'h34, 1'b1, -1, 0, 0, "seqD 34");

    // parity table
    for (int i = 0; i < 6; i++) begin
      m3 = pv[i].m; k3 = pv[i].k; po = pv[i].odd;
      p_frame(pv[i].d, pv[i].pbit, pv[i].exp_t, pv[i].exp_e, $sformatf("pvec%0d", i));
    end

    // short low glitch: no output, next frame still on time
    for (int i = 0; i < 3; i++) b[i] = (i == 0) ? n_trg[0] + n_err[0] : (i == 1) ? n_trg[1] + n_err[1] : 0;
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (30) @(posedge clk);
    chk("glitch s1 quiet", n_trg[0] + n_err[0] - b[0], 0);
    chk("glitch s2 quiet", n_trg[1] + n_err[1] - b[1], 0);
    m1 = 8'hC3; k1 = 8'h00;
    a_frame(8'hC3, 1'b1, 1, -1, 0, "post glitch");

    // reset in the middle of the data bits
    b[0] = n_trg[0] + n_err[0]; b[1] = n_trg[1] + n_err[1];
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid reset outs", int'({t1, e1, t2, e2}), 0);
    #1 rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idx2 = 0;
    repeat (BAUD * 12) @(posedge clk);
    chk("mid reset s1 quiet", n_trg[0] + n_err[0] - b[0], 0);
    chk("mid reset s2 quiet", n_trg[1] + n_err[1] - b[1], 0);
    m1 = 8'hA5; k1 = 8'h00;
    a_frame(8'hA5, 1'b1, 1, -1, 0, "post reset");

    // randomized frames against the reference
    m2 = 16'($urandom); k2 = 16'($urandom & $urandom & $urandom);
    for (int i = 0; i < 24; i++) begin
      m1 = 8'($urandom); k1 = 8'($urandom & $urandom);
      case ($urandom_range(0, 3))
        0: d = m2[7:0] ^ (8'($urandom) & k2[7:0]);
        1: d = m2[15:8] ^ (8'($urandom) & k2[15:8]);
        2: d = m1 ^ (8'($urandom) & k1);
        default: d = 8'($urandom);
      endcase
      good = $urandom_range(0, 7) != 0;
      a_frame(d, good, -1, -1, good ? 0 : 1, $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      m3 = 8'($urandom); k3 = 8'($urandom & $urandom); po = 1'($urandom);
      d = ($urandom_range(0, 1) == 0) ? m3 ^ (8'($urandom) & k3) : 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      pbit_r = {7'd0, (^d) ^ po ^ !good};
      p_frame(d, pbit_r[0], (good && hit(d, m3, k3)) ? 1 : 0, good ? 0 : 1,
              $sformatf("prand%0d", i));
    end

    chk("pulse shape", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
